// File: rtl/io_fifo_interface_if.sv
// CPU data-memory port and UART byte ports of the buffered UART front end.
// The slave modport is the block's side and the master modport is the surrounding system's side.
interface io_fifo_interface_if;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [3:0]  IO_trans;
  logic        IO_recv;
  logic [31:0] ReadData;
  logic [7:0]  UartDataIn;
  logic        UartDataInValid;
  logic        UartDataInReady;
  logic [7:0]  UartDataOut;
  logic        UartDataOutValid;
  logic        UartDataOutReady;

  modport master (
    output Addr, WriteData, IO_trans, IO_recv, UartDataInReady, UartDataOut, UartDataOutValid,
    input  ReadData, UartDataIn, UartDataInValid, UartDataOutReady
  );

  modport slave (
    input  Addr, WriteData, IO_trans, IO_recv, UartDataInReady, UartDataOut, UartDataOutValid,
    output ReadData, UartDataIn, UartDataInValid, UartDataOutReady
  );
endinterface

// File: rtl/io_fifo_interface.sv
// Memory-mapped UART front end: RX/TX byte FIFOs, a status register, sticky
// overflow/drop flags and a flush/clear control register in a 16-byte window.
module io_fifo_interface #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int          RX_DEPTH  = 8,
  parameter int          TX_DEPTH  = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  io_fifo_interface_if.slave   bus
);

  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam int TX_CW = TX_AW + 1;

  localparam logic [31:0] STATUS_ADDR = BASE_ADDR;
  localparam logic [31:0] RX_ADDR     = BASE_ADDR + 32'h4;
  localparam logic [31:0] TX_ADDR     = BASE_ADDR + 32'h8;
  localparam logic [31:0] CTRL_ADDR   = BASE_ADDR + 32'hC;

  logic [7:0]       rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr, rx_rd_ptr;
  logic [RX_CW-1:0] rx_count;
  logic [7:0]       tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr, tx_rd_ptr;
  logic [TX_CW-1:0] tx_count;
  logic             rx_overflow, tx_drop;

  logic rx_full, rx_empty, tx_full, tx_empty;
  logic store, ctrl_wr, clear_flags, flush_rx, flush_tx;
  logic rx_push, rx_pop, rx_ovf_set;
  logic tx_push, tx_pop, tx_push_req, tx_drop_set;
  logic unused_wdata;

  assign rx_full  = (rx_count == RX_CW'(RX_DEPTH));
  assign rx_empty = (rx_count == '0);
  assign tx_full  = (tx_count == TX_CW'(TX_DEPTH));
  assign tx_empty = (tx_count == '0);

  // Store and load strobes are decoded independently so one cycle can do both.
  assign store       = |bus.IO_trans;
  assign ctrl_wr     = store && (bus.Addr == CTRL_ADDR);
  assign clear_flags = ctrl_wr && bus.WriteData[0];
  assign flush_rx    = ctrl_wr && bus.WriteData[1];
  assign flush_tx    = ctrl_wr && bus.WriteData[2];

  // A pop on a full FIFO frees the slot the same-cycle push lands in.
  assign rx_pop     = bus.IO_recv && (bus.Addr == RX_ADDR) && !rx_empty;
  assign rx_push    = bus.UartDataOutValid && (!rx_full || rx_pop);
  assign rx_ovf_set = bus.UartDataOutValid && rx_full && !rx_pop && !flush_rx;

  assign tx_pop      = !tx_empty && bus.UartDataInReady;
  assign tx_push_req = store && (bus.Addr == TX_ADDR);
  assign tx_push     = tx_push_req && (!tx_full || tx_pop);
  assign tx_drop_set = tx_push_req && tx_full && !tx_pop && !flush_tx;

  assign unused_wdata = ^bus.WriteData[31:8];

  // NOTE: state registers use non-blocking assignments so every process sees
  // pre-edge values and simulation order cannot change the result.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (flush_rx) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (flush_tx) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // NOTE: the storage arrays are deliberately not reset; the counts define
  // what is valid and stale entries are never presented.
  always_ff @(posedge Clock) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= bus.UartDataOut;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.WriteData[7:0];
  end

  // A new event in the same cycle as a clear keeps the flag set.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      rx_overflow <= 1'b0;
      tx_drop     <= 1'b0;
    end else begin
      if (rx_ovf_set)       rx_overflow <= 1'b1;
      else if (clear_flags) rx_overflow <= 1'b0;
      if (tx_drop_set)      tx_drop <= 1'b1;
      else if (clear_flags) tx_drop <= 1'b0;
    end
  end

  // NOTE: the default assignment first keeps this combinational block from
  // inferring a latch for unselected addresses.
  always_comb begin
    bus.ReadData = '0;
    case (bus.Addr)
      STATUS_ADDR: bus.ReadData = {8'h00, 8'(tx_count), 8'(rx_count), 3'b000,
                                   tx_drop, tx_empty, rx_overflow, !rx_empty, !tx_full};
      RX_ADDR:     bus.ReadData = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr]};
      default:     bus.ReadData = '0;
    endcase
  end

  assign bus.UartDataInValid  = !tx_empty;
  assign bus.UartDataIn       = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
  assign bus.UartDataOutReady = 1'b1;

endmodule

// File: tb/tb_io_fifo_interface.sv
// Scoreboard bench for io_fifo_interface: stimulus queues expected read data and
// expected UART bytes, and a negedge monitor compares whenever the DUT presents them.
module tb_io_fifo_interface;
  localparam logic [31:0] BASE = 32'h8000_0000;

  typedef struct {
    string       name;
    logic [31:0] value;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_fifo_interface_if bus();

  io_fifo_interface #(.BASE_ADDR(BASE), .RX_DEPTH(8), .TX_DEPTH(8)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  exp_t       rd_q[$];
  logic [7:0] tx_q[$];
  exp_t       rd_e;
  logic [7:0] tx_e;
  bit         rd_chk = 1'b0;
  int         n_tests = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: read data when a read is presented, UART bytes on each handshake.
  always @(negedge clk) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_unexpected: got %h expected none", bus.ReadData);
      end else begin
        rd_e = rd_q.pop_front();
        check(rd_e.name, bus.ReadData, rd_e.value);
      end
    end
    if (bus.UartDataInValid && bus.UartDataInReady) begin
      if (tx_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: got %h expected none", bus.UartDataIn);
      end else begin
        tx_e = tx_q.pop_front();
        check("tx_byte", {24'h0, bus.UartDataIn}, {24'h0, tx_e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] off, input bit pop, input logic [31:0] exp, input string name);
    exp_t e;
    e.name  = name;
    e.value = exp;
    rd_q.push_back(e);
    bus.Addr    = BASE + off;
    bus.IO_recv = pop;
    rd_chk      = 1'b1;
    cyc();
    rd_chk      = 1'b0;
    bus.IO_recv = 1'b0;
    bus.Addr    = '0;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    bus.Addr      = BASE + off;
    bus.WriteData = data;
    bus.IO_trans  = 4'hF;
    cyc();
    bus.IO_trans  = 4'h0;
    bus.WriteData = '0;
    bus.Addr      = '0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    bus.UartDataOut      = b;
    bus.UartDataOutValid = 1'b1;
    cyc();
    bus.UartDataOutValid = 1'b0;
  endtask

  task automatic drain_tx(input string name);
    bus.UartDataInReady = 1'b1;
    for (int i = 0; i < 40 && tx_q.size() != 0; i++) cyc();
    cyc();
    bus.UartDataInReady = 1'b0;
    check(name, tx_q.size(), 0);
  endtask

  initial begin
    bus.Addr = '0;
    bus.WriteData = '0;
    bus.IO_trans = '0;
    bus.IO_recv = 1'b0;
    bus.UartDataInReady = 1'b0;
    bus.UartDataOut = '0;
    bus.UartDataOutValid = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    rd(32'h0, 1'b0, 32'h0000_0009, "reset_status");
    check("reset_valid", bus.UartDataInValid, 0);
    check("reset_uart_in", bus.UartDataIn, 0);
    check("reset_out_ready", bus.UartDataOutReady, 1);

    // RX order plus unmapped / write-only reads returning 0
    rx_byte(8'hAA);
    rx_byte(8'h55);
    rx_byte(8'h01);
    rd(32'h0, 1'b0, 32'h0000_030B, "rx_order_status");
    rd(32'h8, 1'b0, 32'h0, "tx_addr_read");
    rd(32'hC, 1'b0, 32'h0, "ctrl_addr_read");
    rd(32'h10, 1'b0, 32'h0, "outside_window");
    rd(32'h4, 1'b1, 32'h0000_00AA, "rx_pop0");
    rd(32'h4, 1'b1, 32'h0000_0055, "rx_pop1");
    rd(32'h4, 1'b1, 32'h0000_0001, "rx_pop2");
    rd(32'h4, 1'b1, 32'h0, "rx_pop_empty");
    rd(32'h0, 1'b0, 32'h0000_0009, "rx_empty_status");

    // RX overflow
    for (int i = 0; i < 9; i++) rx_byte(8'(i));
    rd(32'h0, 1'b0, 32'h0000_080F, "rx_ovf_status");
    for (int i = 0; i < 8; i++) rd(32'h4, 1'b1, 32'(i), "rx_ovf_pop");
    rd(32'h0, 1'b0, 32'h0000_000D, "rx_ovf_sticky");
    wr(32'hC, 32'h1);
    rd(32'h0, 1'b0, 32'h0000_0009, "rx_ovf_cleared");

    // TX drop and wrap, three rounds
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 9; i++) begin
        if (i < 8) tx_q.push_back(8'hF0 + 8'(i));
        wr(32'h8, 32'h0000_00F0 + 32'(i));
      end
      rd(32'h0, 1'b0, 32'h0008_0010, "tx_full_status");
      drain_tx("tx_drain_left");
      rd(32'h0, 1'b0, 32'h0000_0019, "tx_empty_status");
    end
    wr(32'hC, 32'h1);
    rd(32'h0, 1'b0, 32'h0000_0009, "tx_drop_cleared");

    // Full RX FIFO: pop and UART push in one cycle
    for (int i = 0; i < 8; i++) rx_byte(8'h10 + 8'(i));
    bus.UartDataOut      = 8'h77;
    bus.UartDataOutValid = 1'b1;
    rd(32'h4, 1'b1, 32'h0000_0010, "full_pop_head");
    bus.UartDataOutValid = 1'b0;
    rd(32'h0, 1'b0, 32'h0000_080B, "full_pushpop_status");
    for (int i = 1; i < 8; i++) rd(32'h4, 1'b1, 32'h10 + 32'(i), "full_pop");
    rd(32'h4, 1'b1, 32'h0000_0077, "full_pop_last");
    rd(32'h0, 1'b0, 32'h0000_0009, "full_drained_status");

    // Flush both FIFOs while a byte arrives at a full RX FIFO
    wr(32'h8, 32'hC1);
    wr(32'h8, 32'hC2);
    for (int i = 0; i < 8; i++) rx_byte(8'h20 + 8'(i));
    bus.UartDataOut      = 8'h99;
    bus.UartDataOutValid = 1'b1;
    wr(32'hC, 32'h6);
    bus.UartDataOutValid = 1'b0;
    rd(32'h0, 1'b0, 32'h0000_0009, "flush_status");
    rd(32'h4, 1'b0, 32'h0, "flush_rx_empty");
    check("flush_tx_valid", bus.UartDataInValid, 0);

    // Mid-transfer asynchronous reset
    wr(32'h8, 32'hA1);
    wr(32'h8, 32'hA2);
    wr(32'h8, 32'hA3);
    check("mid_valid_before", bus.UartDataInValid, 1);
    check("mid_head_before", bus.UartDataIn, 32'hA1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_valid_async", bus.UartDataInValid, 0);
    check("mid_uart_in_async", bus.UartDataIn, 0);
    rd(32'h0, 1'b0, 32'h0000_0009, "mid_reset_status");
    rst_n = 1'b1;
    bus.UartDataInReady = 1'b1;
    repeat (3) cyc();
    bus.UartDataInReady = 1'b0;
    rd(32'h0, 1'b0, 32'h0000_0009, "post_reset_status");

    cyc();
    check("rd_queue_left", rd_q.size(), 0);
    check("tx_queue_left", tx_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
